regfile_writeback: RTL and testbench

//  Write-side partner of the DSP core's register file: buffers results from

---
 rtl/regfile_pkg.sv | 14 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 99 +++++++++
 tb/tb_regfile_writeback.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file write-back path.
// Entry layout carries the destination register and the result value together.
package regfile_pkg;
    localparam int REGADDR_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef logic [REGADDR_WIDTH-1:0] regaddr_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;

    typedef struct packed {
        regaddr_t addr;
        data_t    data;
    } wb_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with synchronous active-low reset and a clear input.
// Latency: pushed entry visible at dout the cycle after the push edge.
// Backpressure: caller must honour full; pushes while full are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = CW'(wr_ptr - rd_ptr);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && reset && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/regfile_writeback.sv
// In-order write-back queue feeding the register file's single write port, plus pending-write scoreboard.
// Latency: accepted at edge N, write presented on wr_* after edge N+1; one write per cycle.
// Backpressure: in_ready drops when the queue is full, during flush, or in reset; wr_stall holds issue.
module regfile_writeback import regfile_pkg::*; #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 1 << REGADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REGADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       wr_stall,
    output logic                       wr_enable,
    output logic [REGADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [REGADDR_WIDTH-1:0]   query_addrA,
    input  logic [REGADDR_WIDTH-1:0]   query_addrB,
    output logic                       pendingA,
    output logic                       pendingB,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int SCW = $clog2(DEPTH + 2);

    wb_entry_t       in_entry;
    wb_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [SCW-1:0]  sb_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] sb_inc;
    logic [NUM_REGS-1:0] sb_dec;

    assign in_ready = reset && !flush && !fifo_full;
    // r0 is hardwired zero: the handshake completes but nothing is queued.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = reset && !flush && !wr_stall && !fifo_empty;
    assign in_entry = '{addr: in_addr, data: in_data};

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (pop) begin
            wr_enable <= 1'b1;
            wr_addr   <= head.addr;
            wr_data   <= head.data;
        end else begin
            wr_enable <= 1'b0;
        end
    end

    // An entry stays pending through its issue cycle; it retires at the edge ending that cycle.
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_inc[i] = push && (in_addr == REGADDR_WIDTH'(i));
            sb_dec[i] = wr_enable && (wr_addr == REGADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i < NUM_REGS; i++) sb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                case ({sb_inc[i], sb_dec[i]})
                    2'b10:   sb_cnt[i] <= sb_cnt[i] + 1'b1;
                    2'b01:   sb_cnt[i] <= sb_cnt[i] - 1'b1;
                    default: sb_cnt[i] <= sb_cnt[i];
                endcase
            end
        end
    end

    assign pendingA = (query_addrA != '0) && (sb_cnt[query_addrA] != '0);
    assign pendingB = (query_addrB != '0) && (sb_cnt[query_addrB] != '0);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: inputs change and outputs are sampled at negedge.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_stall;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  query_addrA;
    logic [4:0]  query_addrB;
    logic        pendingA;
    logic        pendingB;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .wr_stall    (wr_stall),
        .wr_enable   (wr_enable),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .query_addrA (query_addrA),
        .query_addrB (query_addrB),
        .pendingA    (pendingA),
        .pendingB    (pendingB),
        .count       (count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_stall = 1'b0; query_addrA = '0; query_addrB = '0;
        tick(); tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_enable got=%0h exp=0", wr_enable); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hA5A5_A5A5; query_addrA = 5'd3;
        #1;
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL single_pend_before got=%0h exp=0", pendingA); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL single_early_we got=%0h exp=0", wr_enable); end
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL single_pend_queued got=%0h exp=1", pendingA); end
        tick();
        checks++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL single_we got=%0h exp=1", wr_enable); end
        checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL single_addr got=%0d exp=3", wr_addr); end
        checks++; if (wr_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_data got=%0h exp=a5a5a5a5", wr_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_issue got=%0d exp=0", count); end
        checks++; if (pendingA !== 1'b1) begin errors++; $display("FAIL single_pend_issuing got=%0h exp=1", pendingA); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL single_we_drop got=%0h exp=0", wr_enable); end
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL single_pend_after got=%0h exp=0", pendingA); end
    endtask

    task automatic test_back_to_back();
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(5 + i); in_data = 32'h5000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%0h exp=0", in_ready); end
        wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL b2b_we[%0d] got=%0h exp=1", i, wr_enable); end
            checks++; if (wr_addr !== 5'(5 + i)) begin errors++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, wr_addr, 5 + i); end
            checks++; if (wr_data !== 32'h5000 + 32'(i)) begin errors++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, wr_data, 32'h5000 + i); end
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop got=%0h exp=1", in_ready); end
            end
        end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL b2b_we_end got=%0h exp=0", wr_enable); end
    endtask

    task automatic test_same_addr();
        query_addrB = 5'd9;
        in_valid = 1'b1; in_addr = 5'd9; in_data = 32'd1;
        tick();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL same_count1 got=%0d exp=1", count); end
        checks++; if (pendingB !== 1'b1) begin errors++; $display("FAIL same_pend_a got=%0h exp=1", pendingB); end
        in_data = 32'd2;
        tick();
        in_valid = 1'b0;
        checks++; if (wr_enable !== 1'b1 || wr_data !== 32'd1) begin errors++; $display("FAIL same_first got we=%0h data=%0h exp we=1 data=1", wr_enable, wr_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL same_count_pushpop got=%0d exp=1", count); end
        checks++; if (pendingB !== 1'b1) begin errors++; $display("FAIL same_pend_b got=%0h exp=1", pendingB); end
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'd2) begin errors++; $display("FAIL same_second got we=%0h addr=%0d data=%0h exp we=1 addr=9 data=2", wr_enable, wr_addr, wr_data); end
        checks++; if (pendingB !== 1'b1) begin errors++; $display("FAIL same_pend_c got=%0h exp=1", pendingB); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL same_we_end got=%0h exp=0", wr_enable); end
        checks++; if (pendingB !== 1'b0) begin errors++; $display("FAIL same_pend_d got=%0h exp=0", pendingB); end
    endtask

    task automatic test_addr_zero();
        query_addrA = 5'd0;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count got=%0d exp=0", count); end
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL zero_pend got=%0h exp=0", pendingA); end
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL zero_no_write got=%0h exp=0", wr_enable); end
    endtask

    task automatic test_flush();
        wr_stall = 1'b1; query_addrA = 5'd10; query_addrB = 5'd12;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'hF000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        checks++; if (pendingA !== 1'b1 || pendingB !== 1'b1) begin errors++; $display("FAIL flush_pre_pend got=%0h%0h exp=11", pendingA, pendingB); end
        wr_stall = 1'b0;
        tick();
        flush = 1'b1; in_valid = 1'b1; in_addr = 5'd13; in_data = 32'h1313;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
        checks++; if (wr_enable !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'hF000) begin errors++; $display("FAIL flush_issuing got we=%0h addr=%0d data=%0h exp we=1 addr=10 data=f000", wr_enable, wr_addr, wr_data); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL flush_we got=%0h exp=0", wr_enable); end
        checks++; if (pendingA !== 1'b0 || pendingB !== 1'b0) begin errors++; $display("FAIL flush_pend got=%0h%0h exp=00", pendingA, pendingB); end
        query_addrA = 5'd13;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_enable !== 1'b0 || count !== 3'd0 || pendingA !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d] got we=%0h count=%0d pend=%0h exp 0/0/0", i, wr_enable, count, pendingA); end
        end
    endtask

    task automatic test_reset_mid();
        wr_stall = 1'b1; query_addrA = 5'd14;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_addr = 5'(14 + i); in_data = 32'hE000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count got=%0d exp=2", count); end
        wr_stall = 1'b0; reset = 1'b0;
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL rmid_we got=%0h exp=0", wr_enable); end
        checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rmid_addr_data got addr=%0d data=%0h exp 0/0", wr_addr, wr_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%0h exp=0", in_ready); end
        checks++; if (pendingA !== 1'b0) begin errors++; $display("FAIL rmid_pend got=%0h exp=0", pendingA); end
        reset = 1'b1;
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL rmid_after_we got=%0h exp=0", wr_enable); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_addr();
        test_addr_zero();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
